// File: rtl/riot_timer_n.sv
// Parametrised RRIOT interval timer: prescaled down-counter with 6530-style
// full-rate countdown after underflow, optional auto-reload and a status register.
module riot_timer_n #(
    parameter int WIDTH = 8,
    parameter int PS0   = 0,
    parameter int PS1   = 3,
    parameter int PS2   = 6,
    parameter int PS3   = 10
) (
    input  logic             phi2,
    input  logic             rst_n,
    input  logic             cs,
    input  logic             we_n,
    input  logic [3:0]       A,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO,
    output logic             OE,
    output logic             irq_n
);

    localparam logic [15:0] LIM0 = 16'((32'd1 << PS0) - 32'd1);
    localparam logic [15:0] LIM1 = 16'((32'd1 << PS1) - 32'd1);
    localparam logic [15:0] LIM2 = 16'((32'd1 << PS2) - 32'd1);
    localparam logic [15:0] LIM3 = 16'((32'd1 << PS3) - 32'd1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [1:0]       sel_q, sel_d;
    logic             irq_en_q, irq_en_d;
    logic             flag_q, flag_d;
    logic             auto_q, auto_d;
    logic             fast_q, fast_d;
    logic [15:0]      presc_q, presc_d;

    logic        load, ctrl_wr, tmr_rd, st_rd, tick;
    logic [15:0] ps_lim;

    always_comb begin
        load    = cs & ~we_n & ~A[3];
        ctrl_wr = cs & ~we_n & A[3] & ~A[0];
        tmr_rd  = cs & we_n & ~A[3] & ~A[0];
        st_rd   = cs & we_n & A[0];
    end

    always_comb begin
        ps_lim = LIM3;
        case (sel_q)
            2'd0:    ps_lim = LIM0;
            2'd1:    ps_lim = LIM1;
            2'd2:    ps_lim = LIM2;
            default: ps_lim = LIM3;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        sel_d    = sel_q;
        irq_en_d = irq_en_q;
        flag_d   = flag_q;
        auto_d   = auto_q;
        fast_d   = fast_q;
        presc_d  = presc_q;
        tick     = 1'b0;
        if (load) begin
            count_d  = DI;
            reload_d = DI;
            sel_d    = A[1:0];
            irq_en_d = A[2];
            flag_d   = 1'b0;
            fast_d   = 1'b0;
            presc_d  = '0;
        end else begin
            if (ctrl_wr) auto_d = DI[0];
            if (tmr_rd) begin
                irq_en_d = A[2];
                flag_d   = 1'b0;
            end
            if (fast_q) begin
                tick = 1'b1;
            end else if (presc_q == ps_lim) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 16'd1;
            end
            // Underflow sets the flag after the read-clear so a coincident read loses.
            if (tick) begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    flag_d = 1'b1;
                    if (auto_q) begin
                        count_d = reload_q;
                        presc_d = '0;
                    end else begin
                        count_d = '1;
                        fast_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '1;
            reload_q <= '1;
            sel_q    <= 2'd3;
            irq_en_q <= 1'b0;
            flag_q   <= 1'b0;
            auto_q   <= 1'b0;
            fast_q   <= 1'b0;
            presc_q  <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            sel_q    <= sel_d;
            irq_en_q <= irq_en_d;
            flag_q   <= flag_d;
            auto_q   <= auto_d;
            fast_q   <= fast_d;
            presc_q  <= presc_d;
        end
    end

    always_comb begin
        DO = '0;
        if (tmr_rd)     DO = count_q;
        else if (st_rd) DO = {flag_q, auto_q, {(WIDTH-2){1'b0}}};
    end

    assign OE    = cs & we_n;
    assign irq_n = ~(flag_q & irq_en_q);

endmodule

// File: tb/tb_riot_timer_n.sv
// Directed bench for riot_timer_n: an 8-bit default instance and a 12-bit
// instance share the bus; bsel picks which one a step talks to.
module tb_riot_timer_n;

    logic        phi2;
    logic        rst_n;
    logic        cs_a, cs_b;
    logic        we_n;
    logic [3:0]  A;
    logic [11:0] di;
    logic [7:0]  do_a;
    logic [11:0] do_b;
    logic        oe_a, oe_b, irq_n_a, irq_n_b;
    logic        bsel;
    int          n_cmp, n_err;

    riot_timer_n u_dut_a (
        .phi2 (phi2), .rst_n(rst_n), .cs(cs_a), .we_n(we_n), .A(A),
        .DI(di[7:0]), .DO(do_a), .OE(oe_a), .irq_n(irq_n_a)
    );

    riot_timer_n #(.WIDTH(12), .PS3(12)) u_dut_b (
        .phi2 (phi2), .rst_n(rst_n), .cs(cs_b), .we_n(we_n), .A(A),
        .DI(di), .DO(do_b), .OE(oe_b), .irq_n(irq_n_b)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic set_cs(input logic v);
        if (bsel) cs_b = v;
        else      cs_a = v;
    endtask

    function automatic logic [31:0] cur_do();
        return bsel ? 32'(do_b) : 32'(do_a);
    endfunction

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, bsel ? 32'(irq_n_b) : 32'(irq_n_a), 32'(exp));
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        set_cs(1'b1); we_n = 1'b0; A = a; di = d;
        tick();
        set_cs(1'b0); we_n = 1'b1;
    endtask

    // Combinational look at DO; cs is dropped again before any edge.
    task automatic peek(input string tag, input logic [3:0] a, input logic [31:0] exp);
        set_cs(1'b1); we_n = 1'b1; A = a;
        #1;
        chk(tag, cur_do(), exp);
        set_cs(1'b0);
    endtask

    // Read held across an edge so its side effects take place.
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        set_cs(1'b1); we_n = 1'b1; A = a;
        #1;
        chk(tag, cur_do(), exp);
        tick();
        set_cs(1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; we_n = 1'b1; A = '0; di = '0; bsel = 1'b0;
        #2;
        chk("rst_irq_n", 32'(irq_n_a), 32'h1);
        chk("rst_do", 32'(do_a), 32'h0);
        chk("rst_oe", 32'(oe_a), 32'h0);
        chk("rst_irq_n_b", 32'(irq_n_b), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        peek("rst_status", 4'h9, 32'h00);
        set_cs(1'b1); we_n = 1'b1; A = 4'h0; #1;
        chk("oe_on_read", 32'(oe_a), 32'h1);
        set_cs(1'b0);
        peek("rst_count", 4'h0, 32'hFF);

        // 1x countdown with irq enabled, then fast full-rate countdown
        wr(4'h4, 12'h003);
        peek("s1_load", 4'h0, 32'h03);
        tick(); peek("s1_c2", 4'h0, 32'h02);
        tick(); peek("s1_c1", 4'h0, 32'h01);
        tick(); peek("s1_c0", 4'h0, 32'h00);
        chk_irq("s1_irq_before", 1'b1);
        tick();
        chk_irq("s1_irq_uf", 1'b0);
        peek("s1_status", 4'h9, 32'h80);
        peek("s1_wrap", 4'h0, 32'hFF);
        tick(); peek("s1_fast_fe", 4'h0, 32'hFE);
        tick(); peek("s1_fast_fd", 4'h0, 32'hFD);

        // 8x prescale, irq disabled
        wr(4'h1, 12'h002);
        chk_irq("s2_irq_clr", 1'b1);
        repeat (7) tick();
        peek("s2_c7", 4'h0, 32'h02);
        tick(); peek("s2_c8", 4'h0, 32'h01);
        repeat (7) tick();
        peek("s2_c15", 4'h0, 32'h01);
        tick(); peek("s2_c16", 4'h0, 32'h00);
        repeat (8) tick();
        peek("s2_status", 4'h9, 32'h80);
        peek("s2_wrap", 4'h0, 32'hFF);
        chk_irq("s2_irq_masked", 1'b1);

        // auto-reload
        wr(4'h8, 12'h001);
        peek("s3_ctrl_status", 4'h9, 32'hC0);
        wr(4'h4, 12'h002);
        peek("s3_load", 4'h0, 32'h02);
        peek("s3_status", 4'h9, 32'h40);
        tick(); peek("s3_c1", 4'h0, 32'h01);
        tick(); peek("s3_c0", 4'h0, 32'h00);
        chk_irq("s3_irq_before", 1'b1);
        tick(); peek("s3_reload", 4'h0, 32'h02);
        chk_irq("s3_irq_uf", 1'b0);
        peek("s3_uf_status", 4'h9, 32'hC0);
        tick(); peek("s3_p2_c1", 4'h0, 32'h01);
        tick(); peek("s3_p2_c0", 4'h0, 32'h00);
        tick(); peek("s3_p2_reload", 4'h0, 32'h02);

        // timer read clears flag and irq_en
        rd_chk("rd_do", 4'h0, 32'h02);
        chk_irq("rd_irq_n", 1'b1);
        peek("rd_status", 4'h9, 32'h40);
        peek("rd_count", 4'h0, 32'h01);

        // read coincident with underflow: set wins
        tick();
        rd_chk("coinc_do", 4'h4, 32'h00);
        chk_irq("coinc_irq", 1'b0);
        peek("coinc_status", 4'h9, 32'hC0);
        peek("coinc_reload", 4'h0, 32'h02);

        // auto cleared: next underflow goes to fast mode
        wr(4'h8, 12'h000);
        peek("auto0_status", 4'h9, 32'h80);
        rd_chk("auto0_rd", 4'h0, 32'h01);
        peek("auto0_clr", 4'h9, 32'h00);
        tick();
        peek("auto0_wrap", 4'h0, 32'hFF);
        peek("auto0_flag", 4'h9, 32'h80);
        chk_irq("auto0_irq_masked", 1'b1);
        tick(); peek("auto0_fast", 4'h0, 32'hFE);

        // load in the underflow cycle wins
        wr(4'h4, 12'h001);
        tick();
        peek("lw_c0", 4'h0, 32'h00);
        wr(4'h4, 12'h005);
        chk_irq("lw_irq", 1'b1);
        peek("lw_status", 4'h9, 32'h00);
        peek("lw_count", 4'h0, 32'h05);

        // asynchronous reset mid-count
        repeat (6) tick();
        chk_irq("pre_rst_irq", 1'b0);
        rst_n = 1'b0;
        #1;
        chk_irq("async_rst_irq", 1'b1);
        peek("async_rst_count", 4'h0, 32'hFF);
        peek("async_rst_status", 4'h9, 32'h00);
        rst_n = 1'b1;
        tick();

        // 12-bit instance
        bsel = 1'b1;
        wr(4'h4, 12'h003);
        peek("w12_load", 4'h0, 32'h003);
        tick(); peek("w12_c2", 4'h0, 32'h002);
        tick(); peek("w12_c1", 4'h0, 32'h001);
        tick(); peek("w12_c0", 4'h0, 32'h000);
        chk_irq("w12_irq_before", 1'b1);
        tick();
        chk_irq("w12_irq_uf", 1'b0);
        peek("w12_wrap", 4'h0, 32'hFFF);
        peek("w12_status", 4'h9, 32'h800);
        tick(); peek("w12_fast", 4'h0, 32'hFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riot_timer_n.md
Name: riot_timer_n

Overview:
- Parametrised interval timer for the next-generation RRIOT core, replacing the fixed 8-bit 6530-style timer.
- Sits inside the core on the phi2 domain, behind the registered address/data pads.
- Generalised in counter/bus width and prescaler ratios.
- Adds an auto-reload mode and a status register, neither of which the 6530 timer has.

Parameters:
- WIDTH, 8, counter and data-bus width in bits (min 4).
- PS0, 0, log2 of prescale ratio for select 0 (1x).
- PS1, 3, log2 of ratio for select 1 (8x).
- PS2, 6, log2 of ratio for select 2 (64x).
- PS3, 10, log2 of ratio for select 3 (1024x). PS0 < PS1 < PS2 < PS3 <= 16.

Ports:
- phi2  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  timer select, active high, qualifies every access.
- we_n  in  1  0 = write, 1 = read.
- A  in  4  register address.
- DI  in  WIDTH  write data.
- DO  out  WIDTH  read data; combinational from registered state.
- OE  out  1  cs & we_n; enables the data pad driver.
- irq_n  out  1  active-low interrupt, equal to ~(flag & irq_en).

Behaviour:
- Reset (async, rst_n=0):
  - count = all ones, reload = all ones, sel = 3, irq_en = 0, flag = 0, auto = 0, fast = 0, prescaler = 0.
  - Outputs: irq_n = 1, DO = 0, OE = 0.
- Load write (cs & ~we_n & A[3]=0):
  - count <= DI, reload <= DI, sel <= A[1:0], irq_en <= A[2].
  - flag <= 0, fast <= 0, prescaler <= 0.
  - The load cycle produces no decrement.
- Control write (cs & ~we_n & A[3]=1 & A[0]=0): auto <= DI[0]; nothing else changes.
- Tick, evaluated on every non-load cycle:
  - fast=1: tick every cycle.
  - Otherwise prescaler increments; tick when prescaler == 2^PSsel - 1, and prescaler wraps to 0 on that cycle.
  - PS0 = 0 gives a tick every cycle.
- Tick with count != 0: count <= count - 1.
- Tick with count == 0 (underflow): flag <= 1, then
  - auto=0: count <= all ones, fast <= 1 (6530 behaviour: full-rate countdown continues until the next load).
  - auto=1: count <= reload, fast unchanged (stays 0), prescaler restarts.
- Timer read (cs & we_n & A[3]=0 & A[0]=0):
  - DO = count, irq_en <= A[2], flag <= 0.
  - fast is not cleared.
- Status read (cs & we_n & A[0]=1):
  - DO = {flag, auto, (WIDTH-2) zeros}; no side effects.
- Any other read: DO = 0. When cs=0: DO = 0, no state change.
- Simultaneous events:
  - Underflow in the same cycle as a timer read: set wins, flag = 1 afterwards.
  - The read returns count as it was before the edge.
- Load in the same cycle as an underflow: load wins; flag = 0.
- Changing auto mid-count takes effect at the next underflow only.
- Reset mid-count: immediate return to reset values; irq_n deasserts asynchronously.
- Latency from the triggering edge:
  - Load to first decrement: 2^PSsel cycles.
  - Underflow to irq_n low: same edge, if irq_en = 1.

Test Plan:
- WIDTH=8. Load DI=0x03, A=0b0100 (sel 0, irq_en) -> count 2,1,0 on the next 3 edges, underflow on the 4th: count=0xFF, flag=1, irq_n=0. Then 0xFE, 0xFD on each following edge.
- Load DI=0x02, A=0b0001 (sel 1, 8x) -> count=1 after 8 cycles, 0 after 16, 0xFF with flag=1 after 24; irq_n stays 1 because irq_en=0.
- Control write DI=0x01, then load DI=0x02, A=0b0100 -> underflow on the 3rd edge reloads 0x02; flag=1, irq_n=0. Period 3 cycles repeats with no fast mode.
- After underflow, timer read at A=0b0000 -> DO = current count, flag=0, irq_n=1, irq_en=0. Status read at A=0b1001 -> DO = 0x40 when auto=1, 0x00 when auto=0.
- Timer read coincident with underflow -> DO = 0x00, and flag = 1 afterwards.
- Assert rst_n=0 mid-count with irq_n=0 -> irq_n=1 and count=0xFF without a clock edge. Repeat the first scenario with WIDTH=12, PS3=12 and a 12-bit load of 0x003 -> wrap to 0xFFF.
